// File: rtl/wb_stage.sv
// Writeback stage: single writer of the register-file write port.
// Accepts retiring instructions from MEM; ALU results write one cycle after
// acceptance, loads wait for dmem read data and are extracted/extended first.
// Optional feature macro: WB_FWD_EN exposes the current write as a bypass
// to ID; when undefined the fwd_* outputs are tied to zero.
module wb_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  mem_is_load,
  input  logic [2:0]            mem_ld_type,
  input  logic [1:0]            mem_addr_lo,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  ld_pending,
  output logic [ADDR_WIDTH-1:0] ld_pending_rd,
  output logic [31:0]           wb_count,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] LD_LB  = 3'b000;
  localparam logic [TYPE_W-1:0] LD_LH  = 3'b001;
  localparam logic [TYPE_W-1:0] LD_LBU = 3'b100;
  localparam logic [TYPE_W-1:0] LD_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic [ADDR_WIDTH-1:0]   ld_rd_q, ld_rd_d;
  logic                    ld_wen_q, ld_wen_d;
  logic [TYPE_W-1:0]       ld_type_q, ld_type_d;
  logic [1:0]              ld_lo_q, ld_lo_d;
  logic [CNT_W-1:0]        wb_count_q, wb_count_d;

  logic [7:0]              ld_byte_c;
  logic [15:0]             ld_half_c;
  logic [DATA_WIDTH-1:0]   ld_data_c;

  // Select and extend the loaded byte/halfword/word from the raw read data.
  always_comb begin
    ld_byte_c = dmem_rdata[{ld_lo_q, 3'b000} +: 8];
    ld_half_c = dmem_rdata[{ld_lo_q[1], 4'b0000} +: 16];
    ld_data_c = dmem_rdata;
    case (ld_type_q)
      LD_LB:   ld_data_c = {{(DATA_WIDTH-8){ld_byte_c[7]}}, ld_byte_c};
      LD_LBU:  ld_data_c = {{(DATA_WIDTH-8){1'b0}}, ld_byte_c};
      LD_LH:   ld_data_c = {{(DATA_WIDTH-16){ld_half_c[15]}}, ld_half_c};
      LD_LHU:  ld_data_c = {{(DATA_WIDTH-16){1'b0}}, ld_half_c};
      default: ld_data_c = dmem_rdata;
    endcase
  end

  // Next-state and next-output logic; rf_wen defaults low so writes are pulses.
  always_comb begin
    state_d    = state_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    ld_rd_d    = ld_rd_q;
    ld_wen_d   = ld_wen_q;
    ld_type_d  = ld_type_q;
    ld_lo_d    = ld_lo_q;
    wb_count_d = wb_count_q + CNT_W'(rf_wen_q);

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (mem_is_load) begin
            ld_rd_d   = mem_rd;
            ld_wen_d  = mem_wen;
            ld_type_d = mem_ld_type;
            ld_lo_d   = mem_addr_lo;
            state_d   = WAIT_LOAD;
          end else if (mem_wen && (mem_rd != '0)) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = mem_rd;
            rf_wdata_d = mem_result;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          if (ld_wen_q && (ld_rd_q != '0)) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = ld_data_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any pending load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      ld_rd_q    <= '0;
      ld_wen_q   <= 1'b0;
      ld_type_q  <= '0;
      ld_lo_q    <= '0;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      ld_rd_q    <= ld_rd_d;
      ld_wen_q   <= ld_wen_d;
      ld_type_q  <= ld_type_d;
      ld_lo_q    <= ld_lo_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign mem_ready     = (state_q == IDLE);
  assign ld_pending    = (state_q == WAIT_LOAD);
  assign ld_pending_rd = ld_rd_q;
  assign rf_wen        = rf_wen_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign wb_count      = wb_count_q;

`ifdef WB_FWD_EN
  // Bypass mirrors the registered write so ID can resolve same-cycle reads.
  assign fwd_valid = rf_wen_q;
  assign fwd_addr  = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: cycle-level reference model plus
// directed vectors with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_ready, mem_wen, mem_is_load;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_wen, ld_pending, fwd_valid;
  logic [4:0]  rf_waddr, ld_pending_rd, fwd_addr;
  logic [31:0] rf_wdata, wb_count, fwd_data;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_rd(mem_rd), .mem_result(mem_result), .mem_is_load(mem_is_load),
    .mem_ld_type(mem_ld_type), .mem_addr_lo(mem_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ld_pending(ld_pending), .ld_pending_rd(ld_pending_rd),
    .wb_count(wb_count),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic view of load extraction on a 32-bit little-endian word.
  function automatic logic [31:0] model_extract(input logic [2:0] t, input logic [1:0] lo,
                                                input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (t)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Reference model: one outstanding-load record and the last issued write.
  logic        m_busy, m_pwen, m_wen;
  logic [4:0]  m_prd, m_addr;
  logic [2:0]  m_ptype;
  logic [1:0]  m_plo;
  logic [31:0] m_data, m_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_pwen <= 1'b0; m_prd <= '0; m_ptype <= '0; m_plo <= '0;
      m_wen <= 1'b0; m_addr <= '0; m_data <= '0; m_cnt <= '0;
    end else begin
      if (m_wen) m_cnt <= m_cnt + 32'd1;
      m_wen <= 1'b0;
      if (!m_busy) begin
        if (mem_valid && mem_is_load) begin
          m_busy <= 1'b1; m_pwen <= mem_wen; m_prd <= mem_rd;
          m_ptype <= mem_ld_type; m_plo <= mem_addr_lo;
        end else if (mem_valid && mem_wen && mem_rd != 0) begin
          m_wen <= 1'b1; m_addr <= mem_rd; m_data <= mem_result;
        end
      end else if (dmem_rvalid) begin
        m_busy <= 1'b0;
        if (m_pwen && m_prd != 0) begin
          m_wen <= 1'b1; m_addr <= m_prd;
          m_data <= model_extract(m_ptype, m_plo, dmem_rdata);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("mem_ready", 32'(mem_ready), 32'(!m_busy));
    chk("ld_pending", 32'(ld_pending), 32'(m_busy));
    if (m_busy) chk("ld_pending_rd", 32'(ld_pending_rd), 32'(m_prd));
    chk("rf_wen", 32'(rf_wen), 32'(m_wen));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
    chk("rf_wdata", rf_wdata, m_data);
    chk("wb_count", wb_count, m_cnt);
`ifdef WB_FWD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(m_wen));
    chk("fwd_addr", 32'(fwd_addr), 32'(m_addr));
    chk("fwd_data", fwd_data, m_data);
`else
    chk("fwd_valid", 32'(fwd_valid), 32'd0);
    chk("fwd_addr", 32'(fwd_addr), 32'd0);
    chk("fwd_data", fwd_data, 32'd0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_wen = 1'b0; mem_rd = '0; mem_result = '0;
    mem_is_load = 1'b0; mem_ld_type = '0; mem_addr_lo = '0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] res);
    mem_valid = 1'b1; mem_is_load = 1'b0; mem_wen = 1'b1; mem_rd = rd; mem_result = res;
  endtask

  // Load with rvalid already high in the acceptance cycle (must be ignored).
  task automatic do_load(input string name, input logic [2:0] t, input logic [1:0] lo,
                         input logic [4:0] rd, input logic wen, input logic [31:0] exp);
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_wen = wen; mem_rd = rd;
    mem_ld_type = t; mem_addr_lo = lo; mem_result = 32'hCAFE_0000;
    dmem_rdata = 32'h8081_F2F3; dmem_rvalid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk({name, "_no_early"}, 32'(rf_wen), 32'd0);
    chk({name, "_busy"}, 32'(mem_ready), 32'd0);
    step();
    dmem_rvalid = 1'b0;
    chk({name, "_wen"}, 32'(rf_wen), 32'(wen && rd != 0));
    if (wen && rd != 0) begin
      chk({name, "_addr"}, 32'(rf_waddr), 32'(rd));
      chk({name, "_data"}, rf_wdata, exp);
    end
    chk({name, "_ready"}, 32'(mem_ready), 32'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] cnt_before;
    rstn = 1'b0;
    idle_inputs();
    dmem_rdata = '0;
    step();
    step();
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_wb_count", wb_count, 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_ld_pending", 32'(ld_pending), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    rstn = 1'b1;
    step();

    // ALU burst on consecutive cycles.
    set_alu(5'd3, 32'h11);
    step(); chk("burst0_addr", 32'(rf_waddr), 32'd3); chk("burst0_data", rf_wdata, 32'h11);
    set_alu(5'd4, 32'h22);
    step(); chk("burst1_wen", 32'(rf_wen), 32'd1); chk("burst1_data", rf_wdata, 32'h22);
    set_alu(5'd5, 32'h33);
    step(); chk("burst2_addr", 32'(rf_waddr), 32'd5); chk("burst2_data", rf_wdata, 32'h33);
    idle_inputs();
    step(); chk("burst_end_wen", 32'(rf_wen), 32'd0); chk("burst_count", wb_count, 32'd3);

    // Zero destination: no write, count unchanged, outputs hold.
    set_alu(5'd0, 32'hDEAD_BEEF);
    step(); chk("zero_wen", 32'(rf_wen), 32'd0);
    idle_inputs();
    step(); chk("zero_count", wb_count, 32'd3); chk("zero_hold_addr", 32'(rf_waddr), 32'd5);
    chk("zero_hold_data", rf_wdata, 32'h33);

    // Loads on 0x8081F2F3.
    do_load("lb1",  3'b000, 2'd1, 5'd10, 1'b1, 32'hFFFF_FFF2);
    do_load("lbu3", 3'b100, 2'd3, 5'd11, 1'b1, 32'h0000_0080);
    do_load("lh2",  3'b001, 2'd2, 5'd12, 1'b1, 32'hFFFF_8081);
    do_load("lhu0", 3'b101, 2'd0, 5'd13, 1'b1, 32'h0000_F2F3);
    do_load("lw",   3'b010, 2'd0, 5'd14, 1'b1, 32'h8081_F2F3);
    do_load("lb0",  3'b000, 2'd0, 5'd15, 1'b1, 32'hFFFF_FFF3);
    do_load("lbu2", 3'b100, 2'd2, 5'd16, 1'b1, 32'h0000_0081);
    do_load("lh1",  3'b001, 2'd1, 5'd17, 1'b1, 32'hFFFF_F2F3);
    do_load("lhu3", 3'b101, 2'd3, 5'd18, 1'b1, 32'h0000_8081);
    do_load("ld011", 3'b011, 2'd1, 5'd19, 1'b1, 32'h8081_F2F3);
    cnt_before = wb_count;
    do_load("ld_nowen", 3'b010, 2'd0, 5'd6, 1'b0, 32'h0);
    do_load("ld_rd0",   3'b010, 2'd0, 5'd0, 1'b1, 32'h0);
    chk("ld_nowrite_count", wb_count, cnt_before);
    chk("ld_count_lit", wb_count, 32'd13);

    // Load held waiting for data.
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_wen = 1'b1; mem_rd = 5'd7;
    mem_ld_type = 3'b010; dmem_rvalid = 1'b0; dmem_rdata = 32'h1234_5678;
    step();
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wait_ready", 32'(mem_ready), 32'd0);
      chk("wait_pending", 32'(ld_pending), 32'd1);
      chk("wait_rd", 32'(ld_pending_rd), 32'd7);
      step();
    end
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("wait_wen", 32'(rf_wen), 32'd1);
    chk("wait_addr", 32'(rf_waddr), 32'd7);
    chk("wait_data", rf_wdata, 32'h1234_5678);
    chk("wait_ready_after", 32'(mem_ready), 32'd1);
    step();

    // Reset in the middle of a load discards it.
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_wen = 1'b1; mem_rd = 5'd8;
    mem_ld_type = 3'b010;
    step();
    mem_valid = 1'b0;
    chk("rstmid_pending", 32'(ld_pending), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstmid_count", wb_count, 32'd0);
    chk("rstmid_ready", 32'(mem_ready), 32'd1);
    step();
    rstn = 1'b1;
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    chk("rstmid_no_wen", 32'(rf_wen), 32'd0);
    chk("rstmid_idle", 32'(mem_ready), 32'd1);
    chk("rstmid_count2", wb_count, 32'd0);
    step();
    chk("rstmid_no_wen2", 32'(rf_wen), 32'd0);

    // Bypass visibility in the write cycle.
    set_alu(5'd9, 32'h55);
    step();
    idle_inputs();
`ifdef WB_FWD_EN
    chk("fwd_valid_lit", 32'(fwd_valid), 32'd1);
    chk("fwd_addr_lit", 32'(fwd_addr), 32'd9);
    chk("fwd_data_lit", fwd_data, 32'h55);
`else
    chk("fwd_valid_lit", 32'(fwd_valid), 32'd0);
    chk("fwd_addr_lit", 32'(fwd_addr), 32'd0);
    chk("fwd_data_lit", fwd_data, 32'd0);
`endif
    chk("fwd_case_wen", 32'(rf_wen), 32'd1);
    step();
    step();
    chk("final_count", wb_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage CPU: the single writer of the register file's write port. It accepts retiring instructions from the MEM stage over a valid/ready handshake. ALU results are written one cycle after acceptance. Loads wait for data memory read data, then have their bytes extracted and sign- or zero-extended before being written. It also reports in-flight loads so ID can interlock.

## Interface
- `DATA_WIDTH`, default 32: register and data width.
- `ADDR_WIDTH`, default 5: register index width (32 registers).

Ports:
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `mem_valid` in 1: MEM offers an instruction.
- `mem_ready` out 1: stage can accept this cycle.
- `mem_wen` in 1: instruction writes a register.
- `mem_rd` in ADDR_WIDTH: destination register.
- `mem_result` in DATA_WIDTH: ALU result (ignored for loads).
- `mem_is_load` in 1: instruction is a load.
- `mem_ld_type` in 3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes behave as lw.
- `mem_addr_lo` in 2: low bits of the load address.
- `dmem_rvalid` in 1: load data valid.
- `dmem_rdata` in DATA_WIDTH: raw load word.
- `rf_wen` out 1: register-file write enable.
- `rf_waddr` out ADDR_WIDTH: register-file write address.
- `rf_wdata` out DATA_WIDTH: register-file write data.
- `ld_pending` out 1: a load is awaiting data.
- `ld_pending_rd` out ADDR_WIDTH: destination of the pending load.
- `wb_count` out 32: count of register writes issued.
- `fwd_valid` out 1: bypass valid (see Configuration).
- `fwd_addr` out ADDR_WIDTH: bypass register index.
- `fwd_data` out DATA_WIDTH: bypass data.

## Operation
- Two states: IDLE and WAIT_LOAD.
- `mem_ready` = 1 in IDLE, 0 in WAIT_LOAD (combinational from state).
- Acceptance: `mem_valid & mem_ready` at a rising edge.
- IDLE, accept with `mem_is_load`=0:
  - Next cycle `rf_wen` = `mem_wen & (mem_rd != 0)`, `rf_waddr` = `mem_rd`, `rf_wdata` = `mem_result`.
  - State stays IDLE, so back-to-back acceptance is possible every cycle.
- IDLE, accept with `mem_is_load`=1:
  - Latch `mem_rd`, `mem_wen`, `mem_ld_type`, `mem_addr_lo`; go to WAIT_LOAD.
  - `rf_wen` = 0 next cycle.
- WAIT_LOAD:
  - `ld_pending` = 1 and `ld_pending_rd` = latched rd.
  - On `dmem_rvalid`=1: next cycle `rf_wen` = `latched_wen & (latched_rd != 0)`, `rf_wdata` = extracted data, state returns to IDLE.
- Extraction:
  - lb/lbu select byte `addr_lo` (0 = bits 7:0), then sign- or zero-extend.
  - lh/lhu select halfword `addr_lo[1]` (`addr_lo[0]` ignored), then extend.
  - lw passes the whole word.
- `dmem_rvalid` is ignored in IDLE, including in the acceptance cycle itself.
- Register 0 is never written: `rf_wen` stays 0 when the destination is 0, and `wb_count` does not increment.
- `wb_count` increments by 1 in each cycle `rf_wen`=1 and wraps modulo 2^32.
- `rf_wen` is a one-cycle pulse per write. `rf_waddr`/`rf_wdata` hold their last values when `rf_wen`=0.

## Timing
- Reset values: state IDLE, `rf_wen` 0, `rf_waddr` 0, `rf_wdata` 0, `ld_pending` 0, `ld_pending_rd` 0, `wb_count` 0, `fwd_*` 0.
- Reset mid-load discards the pending load; no write is issued afterwards.
- Latency, ALU ops: acceptance at edge N gives `rf_wen` high in cycle N..N+1.
- Latency, loads: `rvalid` sampled at edge M gives `rf_wen` high in cycle M..M+1. The earliest M is acceptance + 1.
- All outputs are registered except `mem_ready`, `ld_pending`, and `fwd_*`, which are combinational from registered state.

## Configuration
- `WB_FWD_EN` defined:
  - `fwd_valid` = `rf_wen`, `fwd_addr` = `rf_waddr`, `fwd_data` = `rf_wdata`.
  - ID muxes these over register-file read data on an address match, resolving same-cycle write/read.
- `WB_FWD_EN` undefined: `fwd_valid`, `fwd_addr`, `fwd_data` are tied to 0.

## Test plan
- ALU burst: accept rd=3/0x11, rd=4/0x22, rd=5/0x33 on consecutive cycles → three consecutive `rf_wen` pulses with matching addr/data; `wb_count`=3.
- Zero destination: accept rd=0, `mem_wen`=1, result 0xDEADBEEF → `rf_wen` stays 0 and `wb_count` is unchanged.
- Loads with `dmem_rdata`=0x8081F2F3:
  - lb, addr_lo=1 → 0xFFFFFFF2; lbu, addr_lo=3 → 0x00000080.
  - lh, addr_lo=2 → 0xFFFF8081; lhu, addr_lo=0 → 0x0000F2F3; lw → 0x8081F2F3.
- Load wait: accept lw to rd=7, hold `rvalid`=0 for 4 cycles → `mem_ready`=0, `ld_pending`=1, `ld_pending_rd`=7 throughout. `rvalid`=1 → write to rd 7 next cycle, then `mem_ready`=1.
- Reset mid-load: assert `rstn`=0 in WAIT_LOAD, release, then pulse `rvalid` → no `rf_wen`, state IDLE, `wb_count`=0.
- `WB_FWD_EN` on/off: ALU write rd=9/0x55 → with macro, `fwd_valid`=1, `fwd_addr`=9, `fwd_data`=0x55 in the write cycle; without macro, all three are 0.
